regfile_read_arbiter: RTL

Shares the register file's two read ports (32 x 64-bit, 5-bit read selects, combinational read data) among NUM_REQ requesters, e.g. decode, debug and a test harness. Each request asks for two registers and is granted round-robin. The block drives the read selects in the grant cycle and returns both 64-bit values one cycle later through a single registered response stage with backpressure. It sits between the requesters and the register file read path.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/regfile_read_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file read-path constants and the read arbiter state type.
package regfile_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned BUSY_W    = 16;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    STALL
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr
// (wrapping modulo NUM_REQ) wins, but only while enable is high.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant  = '0;
    winner = '0;
    idx    = 0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // ptr is always below NUM_REQ, so a single subtraction wraps the index
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (enable && !found && req[ID_W'(idx)]) begin
        found              = 1'b1;
        grant[ID_W'(idx)]  = 1'b1;
        winner             = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register file's two read ports among NUM_REQ requesters, round-robin,
// returning both values through one registered response stage with backpressure.
module regfile_read_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_reg1,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_reg2,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ADDR_W-1:0]              readRegister1,
  output logic [ADDR_W-1:0]              readRegister2,
  input  logic [DATA_W-1:0]              readData1,
  input  logic [DATA_W-1:0]              readData2,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [ID_W-1:0]                resp_id,
  output logic [DATA_W-1:0]              resp_data1,
  output logic [DATA_W-1:0]              resp_data2,
  output logic [15:0]                    busy_cycles
);

  import regfile_pkg::*;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    ptr_next;
  logic               can_issue;
  logic               granted;
  arb_state_t         state_c;

  // The stage can take a new response when it is empty or retiring this cycle
  assign can_issue = !resp_valid || resp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .enable (can_issue && !reset),
    .grant  (grant),
    .winner (winner)
  );

  assign granted   = |grant;
  assign req_ready = grant;
  assign ptr_next  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  // Idle selects park on the zero register so the file sees a fixed address
  always_comb begin
    readRegister1 = ADDR_W'(ZERO_REG);
    readRegister2 = ADDR_W'(ZERO_REG);
    if (granted) begin
      readRegister1 = req_reg1[winner];
      readRegister2 = req_reg2[winner];
    end
  end

  always_comb begin
    state_c = IDLE;
    if (granted) begin
      state_c = ISSUE;
    end else if (resp_valid && !resp_ready) begin
      state_c = STALL;
    end
  end

  // Response stage, rotation pointer and stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_data1  <= '0;
      resp_data2  <= '0;
      rr_ptr      <= '0;
      busy_cycles <= '0;
    end else begin
      if (state_c == ISSUE) begin
        resp_valid <= 1'b1;
        resp_id    <= winner;
        resp_data1 <= readData1;
        resp_data2 <= readData2;
        rr_ptr     <= ptr_next;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
      if (state_c == STALL && busy_cycles != 16'hFFFF) begin
        busy_cycles <= busy_cycles + 16'd1;
      end
    end
  end

endmodule
